// File: rtl/axi4lite_pkg.sv
// Shared types, response codes and the byte-strobe merge used by the AXI4-Lite register slave.
package axi4lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Widest supported data bus; narrower buses are zero-extended into the merge helper.
    localparam int unsigned MAX_DATA_W = 64;

    typedef enum logic {R_IDLE, R_DATA} rd_state_t;
    typedef enum logic {W_IDLE, W_RESP} wr_state_t;

    function automatic logic [MAX_DATA_W-1:0] strb_merge(
        input logic [MAX_DATA_W-1:0]   old_val,
        input logic [MAX_DATA_W-1:0]   new_val,
        input logic [MAX_DATA_W/8-1:0] strb
    );
        logic [MAX_DATA_W-1:0] res;
        for (int b = 0; b < MAX_DATA_W / 8; b++) begin
            res[b*8 +: 8] = strb[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axi4lite_reg_bank.sv
// Register array with a byte-strobed write port, combinational read port and range flags.
module axi4lite_reg_bank
    import axi4lite_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       we_i,
    input  logic [ADDR_W-1:0]          waddr_i,
    input  logic [DATA_W-1:0]          wdata_i,
    input  logic [DATA_W/8-1:0]        wstrb_i,
    input  logic [ADDR_W-1:0]          raddr_i,
    output logic [DATA_W-1:0]          rdata_o,
    output logic                       rd_oor_o,
    output logic                       wr_oor_o,
    output logic [NUM_REGS*DATA_W-1:0] regs_o
);

    localparam int unsigned OFF_W  = $clog2(DATA_W / 8);
    localparam int unsigned IDX_W  = ADDR_W - OFF_W;
    localparam int unsigned REG_IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [DATA_W-1:0]     regs_q [NUM_REGS];
    logic [DATA_W-1:0]     regs_d [NUM_REGS];
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      w_idx;
    logic [MAX_DATA_W-1:0] merged;
    logic                  unused_ok;

    assign r_idx    = raddr_i[ADDR_W-1:OFF_W];
    assign w_idx    = waddr_i[ADDR_W-1:OFF_W];
    assign rd_oor_o = (r_idx >= IDX_W'(NUM_REGS));
    assign wr_oor_o = (w_idx >= IDX_W'(NUM_REGS));
    assign rdata_o  = rd_oor_o ? '0 : regs_q[r_idx[REG_IW-1:0]];

    // Byte-offset bits never select anything; merge bits above DATA_W are discarded.
    assign unused_ok = ^{raddr_i[OFF_W-1:0], waddr_i[OFF_W-1:0], merged};

    always_comb begin
        regs_d = regs_q;
        merged = strb_merge(MAX_DATA_W'(regs_q[w_idx[REG_IW-1:0]]), MAX_DATA_W'(wdata_i),
                            (MAX_DATA_W/8)'(wstrb_i));
        if (we_i && !wr_oor_o) begin
            regs_d[w_idx[REG_IW-1:0]] = merged[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign regs_o[k*DATA_W +: DATA_W] = regs_q[k];
    end

endmodule

// File: rtl/axi4lite_slave_regs.sv
// AXI4-Lite slave: independent read and write engines in front of a flat register bank.
module axi4lite_slave_regs
    import axi4lite_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 16
) (
    input  logic                       PCLK,
    input  logic                       PRESETn,
    input  logic [ADDR_W-1:0]          ARADDR,
    input  logic [3:0]                 ARCACHE,
    input  logic [2:0]                 ARPROT,
    input  logic                       ARVALID,
    output logic                       ARREADY,
    output logic [DATA_W-1:0]          RDATA,
    output logic [1:0]                 RRESP,
    output logic                       RVALID,
    input  logic                       RREADY,
    input  logic [ADDR_W-1:0]          AWADDR,
    input  logic [3:0]                 AWCACHE,
    input  logic [2:0]                 AWPROT,
    input  logic                       AWVALID,
    output logic                       AWREADY,
    input  logic [DATA_W-1:0]          WDATA,
    input  logic [DATA_W/8-1:0]        WSTRB,
    input  logic                       WVALID,
    output logic                       WREADY,
    output logic [1:0]                 BRESP,
    output logic                       BVALID,
    input  logic                       BREADY,
    output logic [NUM_REGS*DATA_W-1:0] regs_o
);

    rd_state_t             rd_state_q, rd_state_d;
    wr_state_t             wr_state_q, wr_state_d;
    logic                  rst_done_q;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q, w_held_d;
    logic [ADDR_W-1:0]     awaddr_q, awaddr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
    logic                  bank_we;
    logic [DATA_W-1:0]     bank_rdata;
    logic                  rd_oor;
    logic                  wr_oor;
    logic                  unused_ok;

    assign unused_ok = ^{ARCACHE, ARPROT, AWCACHE, AWPROT};

    assign ARREADY = rst_done_q && (rd_state_q == R_IDLE);
    assign AWREADY = rst_done_q && (wr_state_q == W_IDLE) && !aw_held_q;
    assign WREADY  = rst_done_q && (wr_state_q == W_IDLE) && !w_held_q;
    assign RVALID  = (rd_state_q == R_DATA);
    assign BVALID  = (wr_state_q == W_RESP);
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;
    assign BRESP   = bresp_q;

    axi4lite_reg_bank #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_bank (
        .clk_i    (PCLK),
        .rst_ni   (PRESETn),
        .we_i     (bank_we),
        .waddr_i  (awaddr_q),
        .wdata_i  (wdata_q),
        .wstrb_i  (wstrb_q),
        .raddr_i  (ARADDR),
        .rdata_o  (bank_rdata),
        .rd_oor_o (rd_oor),
        .wr_oor_o (wr_oor),
        .regs_o   (regs_o)
    );

    // Read engine: data is sampled from the bank on the AR handshake edge itself.
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        unique case (rd_state_q)
            R_IDLE: begin
                if (ARVALID && ARREADY) begin
                    rdata_d    = bank_rdata;
                    rresp_d    = rd_oor ? RESP_SLVERR : RESP_OKAY;
                    rd_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (RREADY) begin
                    rd_state_d = R_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        wr_state_d = wr_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bresp_d    = bresp_q;
        bank_we    = 1'b0;
        unique case (wr_state_q)
            W_IDLE: begin
                if (AWVALID && AWREADY) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = AWADDR;
                end
                if (WVALID && WREADY) begin
                    w_held_d = 1'b1;
                    wdata_d  = WDATA;
                    wstrb_d  = WSTRB;
                end
                // Commit one edge after both beats are held.
                if (aw_held_q && w_held_q) begin
                    bank_we    = 1'b1;
                    bresp_d    = wr_oor ? RESP_SLVERR : RESP_OKAY;
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                    wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    wr_state_d = W_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rst_done_q <= 1'b0;
            rd_state_q <= R_IDLE;
            wr_state_q <= W_IDLE;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            bresp_q    <= RESP_OKAY;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
        end else begin
            rst_done_q <= 1'b1;
            rd_state_q <= rd_state_d;
            wr_state_q <= wr_state_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            bresp_q    <= bresp_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
        end
    end

endmodule

// File: tb/tb_axi4lite_slave_regs.sv
// Directed self-checking bench for axi4lite_slave_regs with hand-computed expectations.
module tb_axi4lite_slave_regs;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned NR = 16;

    logic              PCLK = 1'b0;
    logic              PRESETn;
    logic [AW-1:0]     ARADDR;
    logic              ARVALID, ARREADY;
    logic [DW-1:0]     RDATA;
    logic [1:0]        RRESP;
    logic              RVALID, RREADY;
    logic [AW-1:0]     AWADDR;
    logic              AWVALID, AWREADY;
    logic [DW-1:0]     WDATA;
    logic [DW/8-1:0]   WSTRB;
    logic              WVALID, WREADY;
    logic [1:0]        BRESP;
    logic              BVALID, BREADY;
    logic [NR*DW-1:0]  regs_o;
    logic [NR*DW-1:0]  regs_snap;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] rd_data;
    logic [1:0]    rd_resp, wr_resp;
    logic          rd_valid, wr_valid;

    always #5 PCLK = ~PCLK;

    axi4lite_slave_regs #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .NUM_REGS (NR)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .ARADDR  (ARADDR),
        .ARCACHE (4'h0),
        .ARPROT  (3'h0),
        .ARVALID (ARVALID),
        .ARREADY (ARREADY),
        .RDATA   (RDATA),
        .RRESP   (RRESP),
        .RVALID  (RVALID),
        .RREADY  (RREADY),
        .AWADDR  (AWADDR),
        .AWCACHE (4'h0),
        .AWPROT  (3'h0),
        .AWVALID (AWVALID),
        .AWREADY (AWREADY),
        .WDATA   (WDATA),
        .WSTRB   (WSTRB),
        .WVALID  (WVALID),
        .WREADY  (WREADY),
        .BRESP   (BRESP),
        .BVALID  (BVALID),
        .BREADY  (BREADY),
        .regs_o  (regs_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    function automatic logic [DW-1:0] reg_at(input int k);
        return regs_o[k*DW +: DW];
    endfunction

    // AW and W in the same cycle; response observed on the commit edge, then accepted.
    task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [DW/8-1:0] s, output logic v, output logic [1:0] r);
        AWADDR = a; AWVALID = 1'b1; WDATA = d; WSTRB = s; WVALID = 1'b1; BREADY = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        tick();
        v = BVALID; r = BRESP;
        tick();
    endtask

    task automatic axi_read(input logic [AW-1:0] a, output logic v, output logic [DW-1:0] d,
                            output logic [1:0] r);
        ARADDR = a; ARVALID = 1'b1; RREADY = 1'b1;
        tick();
        v = RVALID; d = RDATA; r = RRESP;
        ARVALID = 1'b0;
        tick();
    endtask

    initial begin
        PRESETn = 1'b0;
        ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;
        AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
        repeat (3) tick();

        check("rst_arready", ARREADY, 0);
        check("rst_awready", AWREADY, 0);
        check("rst_wready", WREADY, 0);
        check("rst_rvalid", RVALID, 0);
        check("rst_bvalid", BVALID, 0);
        check("rst_rdata", RDATA, 0);
        check("rst_rresp", RRESP, 0);
        check("rst_bresp", BRESP, 0);
        check("rst_regs_zero", regs_o === '0, 1);

        PRESETn = 1'b1;
        #1;
        check("pre_rst_done_arready", ARREADY, 0);
        tick();
        check("post_rst_arready", ARREADY, 1);
        check("post_rst_awready", AWREADY, 1);
        check("post_rst_wready", WREADY, 1);

        // Same-cycle AW/W, step by step.
        AWADDR = 32'h08; AWVALID = 1'b1; WDATA = 32'hDEADBEEF; WSTRB = 4'hF; WVALID = 1'b1;
        BREADY = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        check("wr_hs_bvalid_not_yet", BVALID, 0);
        check("wr_hs_awready_drop", AWREADY, 0);
        check("wr_hs_wready_drop", WREADY, 0);
        tick();
        check("wr_commit_bvalid", BVALID, 1);
        check("wr_commit_bresp", BRESP, 2'b00);
        check("wr_commit_reg2", reg_at(2), 32'hDEADBEEF);
        tick();
        check("wr_done_bvalid", BVALID, 0);
        check("wr_done_awready", AWREADY, 1);

        ARADDR = 32'h08; ARVALID = 1'b1; RREADY = 1'b0;
        tick();
        ARVALID = 1'b0;
        check("rd_rvalid", RVALID, 1);
        check("rd_rdata", RDATA, 32'hDEADBEEF);
        check("rd_rresp", RRESP, 2'b00);
        check("rd_arready_busy", ARREADY, 0);
        RREADY = 1'b1;
        tick();
        check("rd_done_rvalid", RVALID, 0);
        check("rd_done_arready", ARREADY, 1);

        axi_read(32'h0B, rd_valid, rd_data, rd_resp);
        check("rd_byteoff_data", rd_data, 32'hDEADBEEF);

        // Decoupled W ahead of AW, partial strobes.
        axi_write(32'h0C, 32'hAABBCCDD, 4'hF, wr_valid, wr_resp);
        check("reg3_init", reg_at(3), 32'hAABBCCDD);
        WDATA = 32'h11223344; WSTRB = 4'h5; WVALID = 1'b1; BREADY = 1'b1;
        tick();
        WVALID = 1'b0;
        check("dec_wready_held", WREADY, 0);
        check("dec_awready_open", AWREADY, 1);
        tick();
        tick();
        check("dec_awready_still", AWREADY, 1);
        check("dec_no_bvalid", BVALID, 0);
        check("dec_reg3_untouched", reg_at(3), 32'hAABBCCDD);
        AWADDR = 32'h0C; AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        tick();
        check("dec_bvalid", BVALID, 1);
        check("dec_reg3_merge", reg_at(3), 32'hAA22CC44);
        tick();

        // Read backpressure.
        axi_write(32'h04, 32'h0BADF00D, 4'hF, wr_valid, wr_resp);
        ARADDR = 32'h04; ARVALID = 1'b1; RREADY = 1'b0;
        tick();
        ARVALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("rbp_rvalid", RVALID, 1);
            check("rbp_rdata", RDATA, 32'h0BADF00D);
            check("rbp_rresp", RRESP, 2'b00);
            check("rbp_arready", ARREADY, 0);
            tick();
        end
        RREADY = 1'b1;
        tick();
        check("rbp_release", RVALID, 0);

        // Write backpressure.
        AWADDR = 32'h10; AWVALID = 1'b1; WDATA = 32'h12345678; WSTRB = 4'hF; WVALID = 1'b1;
        BREADY = 1'b0;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("wbp_bvalid", BVALID, 1);
            check("wbp_bresp", BRESP, 2'b00);
            check("wbp_awready", AWREADY, 0);
            check("wbp_wready", WREADY, 0);
            tick();
        end
        check("wbp_reg4", reg_at(4), 32'h12345678);
        BREADY = 1'b1;
        tick();
        check("wbp_release", BVALID, 0);

        // Out of range and empty strobe.
        regs_snap = regs_o;
        axi_write(32'h40, 32'hFFFFFFFF, 4'hF, wr_valid, wr_resp);
        check("oor_wr_bvalid", wr_valid, 1);
        check("oor_wr_bresp", wr_resp, 2'b10);
        check("oor_wr_regs_same", regs_o === regs_snap, 1);
        axi_read(32'h40, rd_valid, rd_data, rd_resp);
        check("oor_rd_rvalid", rd_valid, 1);
        check("oor_rd_rdata", rd_data, 0);
        check("oor_rd_rresp", rd_resp, 2'b10);
        axi_write(32'h08, 32'h00000000, 4'h0, wr_valid, wr_resp);
        check("nostrb_bresp", wr_resp, 2'b00);
        check("nostrb_reg2", reg_at(2), 32'hDEADBEEF);

        // AR handshake on the write commit edge returns the pre-commit value.
        AWADDR = 32'h00; AWVALID = 1'b1; WDATA = 32'h5; WSTRB = 4'hF; WVALID = 1'b1;
        BREADY = 1'b0;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        ARADDR = 32'h00; ARVALID = 1'b1; RREADY = 1'b0;
        tick();
        ARVALID = 1'b0;
        check("coll_rvalid", RVALID, 1);
        check("coll_rdata_old", RDATA, 0);
        check("coll_bvalid", BVALID, 1);
        check("coll_reg0_new", reg_at(0), 32'h5);
        RREADY = 1'b1;
        tick();
        check("coll_bvalid_pending", BVALID, 1);

        PRESETn = 1'b0;
        #1;
        check("midrst_bvalid", BVALID, 0);
        check("midrst_reg0", reg_at(0), 0);
        check("midrst_arready", ARREADY, 0);
        tick();
        PRESETn = 1'b1;
        tick();
        check("midrst_recover_awready", AWREADY, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
